// File: rtl/mode_pkg.sv
// Shared types and constants for the mode selector / mode detector pair.
package mode_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_TWO   = 2'd2,
    MODE_THREE = 2'd3
  } mode_e;

  // The low two bits line up with mode_e so a classification maps directly onto a mode.
  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_COUNT   = 3'd1,
    CLS_TWO     = 3'd2,
    CLS_THREE   = 3'd3,
    CLS_INVALID = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int VAL_ZERO  = 0;
  localparam int VAL_TWO   = 2;
  localparam int VAL_THREE = 3;

  function automatic cls_e mode_to_cls(input mode_e m);
    return cls_e'({1'b0, m});
  endfunction

endpackage

// File: rtl/mode_classifier.sv
// Classifies one observed word against the previous one into the mode that could have produced it.
module mode_classifier
  import mode_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] prev,
  output cls_e              cls
);

  logic [DATA_W-1:0] prev_inc;

  assign prev_inc = prev + DATA_W'(1);

  always_comb begin
    // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
    cls = CLS_INVALID;
    if (data_in == prev_inc) begin
      cls = CLS_COUNT;
    end else if (data_in == prev) begin
      if (data_in == DATA_W'(VAL_ZERO))       cls = CLS_ZERO;
      else if (data_in == DATA_W'(VAL_TWO))   cls = CLS_TWO;
      else if (data_in == DATA_W'(VAL_THREE)) cls = CLS_THREE;
    end
  end

endmodule

// File: rtl/mode_detector.sv
// Recovers the selector mode from its data stream with lock/loss hysteresis and an error counter.
module mode_detector
  import mode_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output mode_e             mode_out,
  output logic              locked,
  output logic              mode_change,
  output logic [7:0]        err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  state_e            state;
  logic [DATA_W-1:0] prev;
  cls_e              cand;
  cls_e              cls;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;

  logic [RUN_W-1:0]  acq_run;
  logic              acq_lock;
  logic [MISS_W-1:0] miss_inc;
  logic              miss_lost;
  logic              cls_match;
  logic [7:0]        err_inc;

  mode_classifier #(.DATA_W(DATA_W)) u_classifier (
    .data_in (data_in),
    .prev    (prev),
    .cls     (cls)
  );

  // Next run length in ACQ: extend a matching candidate, otherwise restart on the new class.
  assign acq_run   = (cls == cand) ? run + RUN_W'(1) : RUN_W'(1);
  assign acq_lock  = (cls != CLS_INVALID) && (acq_run == RUN_W'(LOCK_CNT));
  assign miss_inc  = miss + MISS_W'(1);
  assign miss_lost = (miss_inc == MISS_W'(LOSS_CNT));
  assign cls_match = (cls == mode_to_cls(mode_out));
  assign err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state       <= IDLE;
      prev        <= '0;
      cand        <= CLS_ZERO;
      run         <= '0;
      miss        <= '0;
      mode_out    <= MODE_ZERO;
      locked      <= 1'b0;
      mode_change <= 1'b0;
      err_cnt     <= '0;
    end else begin
      // NOTE: non-blocking default first; the lock branch below overrides it for one cycle.
      mode_change <= 1'b0;
      if (data_valid) begin
        prev <= data_in;
        unique case (state)
          IDLE: begin
            state <= ACQ;
            run   <= '0;
          end
          ACQ: begin
            if (cls == CLS_INVALID) begin
              run <= '0;
            end else begin
              cand <= cls;
              run  <= acq_run;
              if (acq_lock) begin
                state       <= LOCK;
                mode_out    <= mode_e'(cls[1:0]);
                locked      <= 1'b1;
                mode_change <= 1'b1;
              end
            end
          end
          LOCK: begin
            if (!cls_match) begin
              err_cnt <= err_inc;
              if (LOSS_CNT == 1) begin
                state  <= ACQ;
                locked <= 1'b0;
                cand   <= cls;
                run    <= RUN_W'(cls != CLS_INVALID);
              end else begin
                state <= HOLD;
                miss  <= MISS_W'(1);
              end
            end
          end
          HOLD: begin
            if (cls_match) begin
              state <= LOCK;
              miss  <= '0;
            end else begin
              miss    <= miss_inc;
              err_cnt <= err_inc;
              if (miss_lost) begin
                state  <= ACQ;
                locked <= 1'b0;
                miss   <= '0;
                cand   <= cls;
                run    <= RUN_W'(cls != CLS_INVALID);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_detector.sv
// Directed bench for mode_detector with LOCK_CNT=4, LOSS_CNT=3.
module tb_mode_detector;
  import mode_pkg::*;

  logic       clk;
  logic       xrst;
  logic [7:0] data_in;
  logic       data_valid;
  mode_e      mode_out;
  logic       locked;
  logic       mode_change;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  mode_detector #(.DATA_W(8), .LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk         (clk),
    .xrst        (xrst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .mode_out    (mode_out),
    .locked      (locked),
    .mode_change (mode_change),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    xrst       = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    xrst = 1'b1;
  endtask

  // Present one valid word for exactly one rising edge, return just after that edge.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic lk, input logic [1:0] md,
                            input logic mc, input logic [7:0] ec);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".mode"},   32'(mode_out), 32'(md));
    check({tag, ".pulse"},  32'(mode_change), 32'(mc));
    check({tag, ".err"},    32'(err_cnt), 32'(ec));
  endtask

  initial begin
    xrst       = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    #3;
    expect_out("rst_async", 0, 0, 0, 0);

    // Test 1: count stream locks on the fifth valid word.
    do_reset();
    expect_out("t1_reset", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send(8'(10 + i));
      expect_out($sformatf("t1_pre%0d", i), 0, 0, 0, 0);
    end
    send(8'd14);
    expect_out("t1_lock", 1, 1, 1, 0);
    idle_cycle();
    expect_out("t1_pulse_end", 1, 1, 0, 0);
    send(8'd15);
    expect_out("t1_stay", 1, 1, 0, 0);

    // Test 2: lock on constant 2, then relock on count across the 255->0 wrap.
    do_reset();
    for (int i = 0; i < 4; i++) send(8'd2);
    check("t2_pre.locked", 32'(locked), 32'd0);
    send(8'd2);
    expect_out("t2_lock2", 1, 2, 1, 0);
    send(8'd253);
    expect_out("t2_hold1", 1, 2, 0, 1);
    send(8'd254);
    expect_out("t2_hold2", 1, 2, 0, 2);
    send(8'd255);
    expect_out("t2_lost", 0, 2, 0, 3);
    send(8'd0);
    send(8'd1);
    expect_out("t2_acq", 0, 2, 0, 3);
    send(8'd2);
    expect_out("t2_relock", 1, 1, 1, 3);

    // Test 3: one corrupt word on constant 3 costs two mismatches without losing lock.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'd3);
    expect_out("t3_lock3", 1, 3, 1, 0);
    send(8'd3);
    expect_out("t3_steady", 1, 3, 0, 0);
    send(8'd7);
    expect_out("t3_bad1", 1, 3, 0, 1);
    send(8'd3);
    expect_out("t3_bad2", 1, 3, 0, 2);
    send(8'd3);
    expect_out("t3_back", 1, 3, 0, 2);
    send(8'd3);
    expect_out("t3_back2", 1, 3, 0, 2);

    // Test 4: count lock ending at 20, then a run of zeros forces loss and relock on mode 0.
    do_reset();
    for (int i = 16; i <= 20; i++) send(8'(i));
    expect_out("t4_lock1", 1, 1, 1, 0);
    send(8'd0);
    send(8'd0);
    expect_out("t4_hold", 1, 1, 0, 2);
    send(8'd0);
    expect_out("t4_lost", 0, 1, 0, 3);
    send(8'd0);
    send(8'd0);
    expect_out("t4_acq", 0, 1, 0, 3);
    send(8'd0);
    expect_out("t4_relock0", 1, 0, 1, 3);

    // Test 5: test 1 with idle gaps; outputs must not move while data_valid is low.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'(10 + i));
      check($sformatf("t5_locked%0d", i), 32'(locked), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("t5_pulse%0d", i), 32'(mode_change), (i == 4) ? 32'd1 : 32'd0);
      idle_cycle();
      idle_cycle();
      check($sformatf("t5_gap_pulse%0d", i), 32'(mode_change), 32'd0);
      check($sformatf("t5_gap_locked%0d", i), 32'(locked), (i == 4) ? 32'd1 : 32'd0);
    end
    check("t5_mode", 32'(mode_out), 32'd1);
    check("t5_err", 32'(err_cnt), 32'd0);

    // Test 6: asynchronous reset while in HOLD clears everything before the next edge.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'd3);
    send(8'd7);
    expect_out("t6_hold", 1, 3, 0, 1);
    @(posedge clk);
    #2;
    xrst = 1'b0;
    #1;
    expect_out("t6_async", 0, 0, 0, 0);
    @(negedge clk);
    xrst = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(10 + i));
    check("t6_pre.locked", 32'(locked), 32'd0);
    send(8'd14);
    expect_out("t6_relock", 1, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
